// File: rtl/axi_txn_limiter.sv
// axi_txn_limiter: caps outstanding AXI4 writes/reads behind the CDC dst side,
// offers a drain/quiesce handshake and flags underflow/timeout as sticky status.
// All payloads pass through combinationally; only AW/AR valid/ready are gated.

package axi_txn_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        axi_b_t b;
        logic   b_valid;
        axi_r_t r;
        logic   r_valid;
    } axi_resp_t;

endpackage

module axi_txn_limiter #(
    parameter int unsigned MaxWrTxns     = 8,
    parameter int unsigned MaxRdTxns     = 8,
    parameter int unsigned TimeoutCycles = 0,
    parameter type         axi_req_t     = axi_txn_pkg::axi_req_t,
    parameter type         axi_resp_t    = axi_txn_pkg::axi_resp_t
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  axi_req_t   slv_req_i,
    output axi_resp_t  slv_resp_o,
    output axi_req_t   mst_req_o,
    input  axi_resp_t  mst_resp_i,
    input  logic       drain_i,
    output logic       drained_o,
    output logic [7:0] wr_cnt_o,
    output logic [7:0] rd_cnt_o,
    output logic       err_underflow_o,
    output logic       err_timeout_o
);

    localparam logic [7:0]  MAX_WR  = 8'(MaxWrTxns);
    localparam logic [7:0]  MAX_RD  = 8'(MaxRdTxns);
    localparam logic [31:0] TIMEOUT = 32'(TimeoutCycles);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  wr_cnt_q, wr_cnt_d;
    logic [7:0]  rd_cnt_q, rd_cnt_d;
    logic        aw_pend_q, ar_pend_q;
    logic [31:0] wr_wd_q, wr_wd_d;
    logic [31:0] rd_wd_q, rd_wd_d;
    logic        err_underflow_q, err_timeout_q;

    logic aw_block, ar_block;
    logic aw_hs, ar_hs, b_hs, r_last_hs;
    logic underflow_evt, timeout_evt;

    // Counter step: +1 on accept, -1 on completion, both cancel, saturate at 0.
    function automatic logic [7:0] cnt_step(input logic [7:0] cnt,
                                            input logic       inc,
                                            input logic       dec);
        logic [7:0] nxt;
        nxt = cnt;
        if (inc && !dec) begin
            nxt = cnt + 8'd1;
        end else if (dec && !inc && cnt != 8'd0) begin
            nxt = cnt - 8'd1;
        end
        return nxt;
    endfunction

    // Watchdog step: counts stalled cycles while work is outstanding, holds at
    // the limit instead of wrapping, and stays at 0 when disabled.
    function automatic logic [31:0] wd_step(input logic [7:0]  cnt,
                                            input logic        hs,
                                            input logic [31:0] wd);
        logic [31:0] nxt;
        nxt = wd;
        if (cnt == 8'd0 || hs) begin
            nxt = '0;
        end else if (TIMEOUT != 32'd0 && wd != TIMEOUT) begin
            nxt = wd + 32'd1;
        end
        return nxt;
    endfunction

    // Gates use registered state only, so there is no comb path from B/R to
    // AW/AR valid. A request already shown downstream is never withdrawn.
    assign aw_block = ((wr_cnt_q == MAX_WR) || (state_q != RUN)) && !aw_pend_q;
    assign ar_block = ((rd_cnt_q == MAX_RD) || (state_q != RUN)) && !ar_pend_q;

    // Pass-through of every channel with only the AW/AR handshakes masked.
    always_comb begin
        mst_req_o           = slv_req_i;
        mst_req_o.aw_valid  = slv_req_i.aw_valid & ~aw_block;
        mst_req_o.ar_valid  = slv_req_i.ar_valid & ~ar_block;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~aw_block;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~ar_block;
    end

    assign aw_hs     = slv_req_i.aw_valid & ~aw_block & mst_resp_i.aw_ready;
    assign ar_hs     = slv_req_i.ar_valid & ~ar_block & mst_resp_i.ar_ready;
    assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

    assign wr_cnt_d = cnt_step(wr_cnt_q, aw_hs, b_hs);
    assign rd_cnt_d = cnt_step(rd_cnt_q, ar_hs, r_last_hs);
    assign wr_wd_d  = wd_step(wr_cnt_q, b_hs, wr_wd_q);
    assign rd_wd_d  = wd_step(rd_cnt_q, r_last_hs, rd_wd_q);

    assign underflow_evt = (b_hs && wr_cnt_q == 8'd0) || (r_last_hs && rd_cnt_q == 8'd0);
    assign timeout_evt   = (TIMEOUT != 32'd0) && (wr_wd_d == TIMEOUT || rd_wd_d == TIMEOUT);

    // Drain FSM next state: quiesce only once nothing is in flight and no
    // new request slips through in the deciding cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (drain_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!drain_i) begin
                    state_d = RUN;
                end else if (wr_cnt_q == 8'd0 && rd_cnt_q == 8'd0 && !aw_hs && !ar_hs) begin
                    state_d = DRAINED;
                end
            end
            DRAINED: begin
                if (!drain_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Drain FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Outstanding counters and the AW/AR "valid already presented" flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_cnt_q  <= 8'd0;
            rd_cnt_q  <= 8'd0;
            aw_pend_q <= 1'b0;
            ar_pend_q <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            aw_pend_q <= mst_req_o.aw_valid & ~mst_resp_i.aw_ready;
            ar_pend_q <= mst_req_o.ar_valid & ~mst_resp_i.ar_ready;
        end
    end

    // Per-direction response watchdogs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_wd_q <= '0;
            rd_wd_q <= '0;
        end else begin
            wr_wd_q <= wr_wd_d;
            rd_wd_q <= rd_wd_d;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_underflow_q <= 1'b0;
            err_timeout_q   <= 1'b0;
        end else begin
            err_underflow_q <= err_underflow_q | underflow_evt;
            err_timeout_q   <= err_timeout_q | timeout_evt;
        end
    end

    assign drained_o       = (state_q == DRAINED);
    assign wr_cnt_o        = wr_cnt_q;
    assign rd_cnt_o        = rd_cnt_q;
    assign err_underflow_o = err_underflow_q;
    assign err_timeout_o   = err_timeout_q;

endmodule

// File: tb/tb_axi_txn_limiter.sv
// Bench for axi_txn_limiter: two instances share stimulus (dut0: 2 wr/4 rd,
// timeout 16; dut1: 2 wr/1 rd, watchdog off) and are compared to a model.
module tb_axi_txn_limiter;
    import axi_txn_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi_req_t  slv_req;
    axi_resp_t mst_resp;
    logic      drain;

    axi_resp_t  slv_resp0, slv_resp1;
    axi_req_t   mst_req0, mst_req1;
    logic       drained0, drained1, uf0, uf1, to0, to1;
    logic [7:0] wr_cnt0, rd_cnt0, wr_cnt1, rd_cnt1;

    axi_txn_limiter #(.MaxWrTxns(2), .MaxRdTxns(4), .TimeoutCycles(16)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .slv_req_i(slv_req), .slv_resp_o(slv_resp0),
        .mst_req_o(mst_req0), .mst_resp_i(mst_resp), .drain_i(drain), .drained_o(drained0),
        .wr_cnt_o(wr_cnt0), .rd_cnt_o(rd_cnt0), .err_underflow_o(uf0), .err_timeout_o(to0));

    axi_txn_limiter #(.MaxWrTxns(2), .MaxRdTxns(1), .TimeoutCycles(0)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .slv_req_i(slv_req), .slv_resp_o(slv_resp1),
        .mst_req_o(mst_req1), .mst_resp_i(mst_resp), .drain_i(drain), .drained_o(drained1),
        .wr_cnt_o(wr_cnt1), .rd_cnt_o(rd_cnt1), .err_underflow_o(uf1), .err_timeout_o(to1));

    localparam int OW = $bits(axi_req_t) + $bits(axi_resp_t) + 19;
    logic [OW-1:0] obs0, obs1;
    assign obs0 = {mst_req0, slv_resp0, wr_cnt0, rd_cnt0, drained0, uf0, to0};
    assign obs1 = {mst_req1, slv_resp1, wr_cnt1, rd_cnt1, drained1, uf1, to1};

    int checks = 0;
    int fails  = 0;

    // ---------------- reference model ----------------
    int          mw  [2] = '{2, 2};
    int          mr  [2] = '{4, 1};
    int unsigned tmo [2] = '{16, 0};

    int          m_wr [2];
    int          m_rd [2];
    int          m_mode [2];   // 0 run, 1 draining, 2 drained
    bit          m_awp [2];
    bit          m_arp [2];
    int unsigned m_wdw [2];
    int unsigned m_wdr [2];
    bit          m_uf [2];
    bit          m_to [2];

    function automatic bit aw_open(int i);
        return (m_mode[i] == 0 && m_wr[i] < mw[i]) || m_awp[i];
    endfunction
    function automatic bit ar_open(int i);
        return (m_mode[i] == 0 && m_rd[i] < mr[i]) || m_arp[i];
    endfunction
    function automatic bit aw_hs(int i);
        return slv_req.aw_valid && aw_open(i) && mst_resp.aw_ready;
    endfunction
    function automatic bit ar_hs(int i);
        return slv_req.ar_valid && ar_open(i) && mst_resp.ar_ready;
    endfunction
    function automatic bit b_hs();
        return mst_resp.b_valid && slv_req.b_ready;
    endfunction
    function automatic bit r_hs();
        return mst_resp.r_valid && slv_req.r_ready && mst_resp.r.last;
    endfunction
    function automatic int cnt_upd(int c, bit inc, bit dec);
        if (inc && !dec) return c + 1;
        if (dec && !inc && c > 0) return c - 1;
        return c;
    endfunction
    function automatic int unsigned wd_upd(int i, int c, bit hs, int unsigned wd);
        if (c == 0 || hs) return 0;
        if (tmo[i] != 0 && wd != tmo[i]) return wd + 1;
        return wd;
    endfunction
    function automatic int mode_upd(int i);
        case (m_mode[i])
            0: return drain ? 1 : 0;
            1: begin
                if (!drain) return 0;
                if (m_wr[i] == 0 && m_rd[i] == 0 && !aw_hs(i) && !ar_hs(i)) return 2;
                return 1;
            end
            default: return drain ? 2 : 0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_wr[i] <= 0; m_rd[i] <= 0; m_mode[i] <= 0;
                m_awp[i] <= 1'b0; m_arp[i] <= 1'b0;
                m_wdw[i] <= 0; m_wdr[i] <= 0;
                m_uf[i] <= 1'b0; m_to[i] <= 1'b0;
            end else begin
                m_wr[i]   <= cnt_upd(m_wr[i], aw_hs(i), b_hs());
                m_rd[i]   <= cnt_upd(m_rd[i], ar_hs(i), r_hs());
                m_mode[i] <= mode_upd(i);
                m_awp[i]  <= slv_req.aw_valid && aw_open(i) && !mst_resp.aw_ready;
                m_arp[i]  <= slv_req.ar_valid && ar_open(i) && !mst_resp.ar_ready;
                m_wdw[i]  <= wd_upd(i, m_wr[i], b_hs(), m_wdw[i]);
                m_wdr[i]  <= wd_upd(i, m_rd[i], r_hs(), m_wdr[i]);
                m_uf[i]   <= m_uf[i] || (b_hs() && m_wr[i] == 0) || (r_hs() && m_rd[i] == 0);
                m_to[i]   <= m_to[i] || (tmo[i] != 0 &&
                             (wd_upd(i, m_wr[i], b_hs(), m_wdw[i]) == tmo[i] ||
                              wd_upd(i, m_rd[i], r_hs(), m_wdr[i]) == tmo[i]));
            end
        end
    end

    function automatic logic [OW-1:0] exp_obs(int i);
        axi_req_t  q;
        axi_resp_t p;
        q = slv_req;
        q.aw_valid = slv_req.aw_valid && aw_open(i);
        q.ar_valid = slv_req.ar_valid && ar_open(i);
        p = mst_resp;
        p.aw_ready = mst_resp.aw_ready && aw_open(i);
        p.ar_ready = mst_resp.ar_ready && ar_open(i);
        return {q, p, 8'(m_wr[i]), 8'(m_rd[i]), m_mode[i] == 2, m_uf[i], m_to[i]};
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic axi_ax_t rand_ax();
        axi_ax_t a;
        a.id = 4'($urandom); a.addr = $urandom; a.len = 8'($urandom);
        a.size = 3'($urandom); a.burst = 2'($urandom);
        return a;
    endfunction
    function automatic axi_req_t rand_req();
        axi_req_t r;
        r.aw = rand_ax(); r.aw_valid = ($urandom_range(3) != 0);
        r.w.data = $urandom; r.w.strb = 4'($urandom); r.w.last = 1'($urandom);
        r.w_valid = 1'($urandom); r.b_ready = 1'($urandom);
        r.ar = rand_ax(); r.ar_valid = ($urandom_range(3) != 0); r.r_ready = 1'($urandom);
        return r;
    endfunction
    function automatic axi_resp_t rand_resp();
        axi_resp_t p;
        p.aw_ready = 1'($urandom); p.ar_ready = 1'($urandom); p.w_ready = 1'($urandom);
        p.b.id = 4'($urandom); p.b.resp = 2'($urandom); p.b_valid = ($urandom_range(3) == 0);
        p.r.id = 4'($urandom); p.r.data = $urandom; p.r.resp = 2'($urandom);
        p.r.last = 1'($urandom); p.r_valid = ($urandom_range(2) == 0);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; slv_req = '0; mst_resp = '0; drain = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; drain = 1'b0;
        slv_req = rand_req(); mst_resp = rand_resp();
        #1;
        checks++;
        if ({wr_cnt0, rd_cnt0, drained0, uf0, to0} !== 19'd0) begin
            fails++; $display("FAIL reset_status got=%h exp=0", {wr_cnt0, rd_cnt0, drained0, uf0, to0});
        end
        checks++;
        if (mst_req0 !== slv_req) begin
            fails++; $display("FAIL reset_req_passthru got=%h exp=%h", mst_req0, slv_req);
        end
        checks++;
        if (slv_resp1 !== mst_resp) begin
            fails++; $display("FAIL reset_resp_passthru got=%h exp=%h", slv_resp1, mst_resp);
        end
        do_reset();
    endtask

    task automatic test_wr_limit();
        do_reset();
        slv_req.aw_valid = 1'b1; slv_req.b_ready = 1'b1; mst_resp.aw_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            slv_req.aw = rand_ax();
            #1;
            checks++;
            if (slv_resp0.aw_ready !== 1'b1) begin
                fails++; $display("FAIL wr_limit_accept%0d got=%b exp=1", k, slv_resp0.aw_ready);
            end
            tick();
        end
        #1;
        checks++;
        if ({slv_resp0.aw_ready, mst_req0.aw_valid, wr_cnt0} !== {2'b00, 8'd2}) begin
            fails++; $display("FAIL wr_limit_full got=%b/%b/%0d exp=0/0/2",
                              slv_resp0.aw_ready, mst_req0.aw_valid, wr_cnt0);
        end
        mst_resp.b_valid = 1'b1;
        #1;
        checks++;
        if (slv_resp0.aw_ready !== 1'b0) begin
            fails++; $display("FAIL wr_limit_b_same_cycle got=%b exp=0", slv_resp0.aw_ready);
        end
        tick();
        mst_resp.b_valid = 1'b0;
        #1;
        checks++;
        if ({slv_resp0.aw_ready, wr_cnt0} !== {1'b1, 8'd1}) begin
            fails++; $display("FAIL wr_limit_reopen got=%b/%0d exp=1/1", slv_resp0.aw_ready, wr_cnt0);
        end
        tick();
        slv_req.aw_valid = 1'b0;
        #1;
        checks++;
        if (wr_cnt0 !== 8'd2) begin
            fails++; $display("FAIL wr_limit_after got=%0d exp=2", wr_cnt0);
        end
        checks++;
        if (obs0 !== exp_obs(0)) begin
            fails++; $display("FAIL wr_limit_model got=%h exp=%h", obs0, exp_obs(0));
        end
    endtask

    task automatic test_rd_limit();
        do_reset();
        slv_req.ar_valid = 1'b1; slv_req.ar = rand_ax(); slv_req.ar.len = 8'd3;
        slv_req.r_ready = 1'b1; mst_resp.ar_ready = 1'b1;
        tick();
        slv_req.ar = rand_ax();
        for (int b = 0; b < 4; b++) begin
            mst_resp.r_valid = 1'b1; mst_resp.r = '0;
            mst_resp.r.data = $urandom; mst_resp.r.last = (b == 3);
            #1;
            checks++;
            if ({rd_cnt1, slv_resp1.ar_ready, mst_req1.ar_valid} !== {8'd1, 2'b00}) begin
                fails++; $display("FAIL rd_limit_beat%0d got=%0d/%b/%b exp=1/0/0",
                                  b, rd_cnt1, slv_resp1.ar_ready, mst_req1.ar_valid);
            end
            checks++;
            if (obs0 !== exp_obs(0)) begin
                fails++; $display("FAIL rd_limit_model0 beat%0d got=%h exp=%h", b, obs0, exp_obs(0));
            end
            tick();
        end
        mst_resp.r_valid = 1'b0;
        #1;
        checks++;
        if ({rd_cnt1, slv_resp1.ar_ready} !== {8'd0, 1'b1}) begin
            fails++; $display("FAIL rd_limit_release got=%0d/%b exp=0/1", rd_cnt1, slv_resp1.ar_ready);
        end
        tick();
        slv_req.ar_valid = 1'b0;
        #1;
        checks++;
        if (rd_cnt1 !== 8'd1) begin
            fails++; $display("FAIL rd_limit_second got=%0d exp=1", rd_cnt1);
        end
        checks++;
        if (obs1 !== exp_obs(1)) begin
            fails++; $display("FAIL rd_limit_model1 got=%h exp=%h", obs1, exp_obs(1));
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        slv_req.aw_valid = 1'b1; slv_req.b_ready = 1'b1; mst_resp.aw_ready = 1'b1;
        tick();
        mst_resp.b_valid = 1'b1; slv_req.aw = rand_ax();
        #1;
        checks++;
        if (mst_req0.aw_valid !== 1'b1) begin
            fails++; $display("FAIL simul_aw_valid got=%b exp=1", mst_req0.aw_valid);
        end
        #3;
        checks++;
        if (mst_req0.aw_valid !== 1'b1) begin
            fails++; $display("FAIL simul_aw_valid_late got=%b exp=1", mst_req0.aw_valid);
        end
        tick();
        mst_resp.b_valid = 1'b0; slv_req.aw_valid = 1'b0;
        #1;
        checks++;
        if ({wr_cnt0, uf0} !== {8'd1, 1'b0}) begin
            fails++; $display("FAIL simul_cnt got=%0d/%b exp=1/0", wr_cnt0, uf0);
        end
    endtask

    task automatic test_drain();
        do_reset();
        mst_resp.aw_ready = 1'b1; mst_resp.ar_ready = 1'b1;
        slv_req.b_ready = 1'b1; slv_req.r_ready = 1'b1;
        slv_req.aw_valid = 1'b1; tick(); slv_req.aw_valid = 1'b0;
        slv_req.ar_valid = 1'b1; tick(); tick(); slv_req.ar_valid = 1'b0;
        mst_resp.aw_ready = 1'b0; slv_req.aw_valid = 1'b1; slv_req.aw = rand_ax();
        tick();
        drain = 1'b1;
        #1;
        checks++;
        if (mst_req0.aw_valid !== 1'b1) begin
            fails++; $display("FAIL drain_stalled_aw got=%b exp=1", mst_req0.aw_valid);
        end
        tick();
        slv_req.ar_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({mst_req0.aw_valid, slv_resp0.ar_ready, mst_req0.ar_valid} !== 3'b100) begin
                fails++; $display("FAIL drain_gate%0d got=%b exp=100", k,
                                  {mst_req0.aw_valid, slv_resp0.ar_ready, mst_req0.ar_valid});
            end
            tick();
        end
        mst_resp.aw_ready = 1'b1;
        #1;
        checks++;
        if (slv_resp0.aw_ready !== 1'b1) begin
            fails++; $display("FAIL drain_aw_accept got=%b exp=1", slv_resp0.aw_ready);
        end
        tick();
        slv_req.aw_valid = 1'b0;
        mst_resp.b_valid = 1'b1;
        repeat (2) tick();
        mst_resp.b_valid = 1'b0;
        mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({drained0, slv_resp0.ar_ready} !== 2'b00) begin
                fails++; $display("FAIL drain_r%0d got=%b exp=00", k, {drained0, slv_resp0.ar_ready});
            end
            tick();
        end
        mst_resp.r_valid = 1'b0;
        #1;
        checks++;
        if ({wr_cnt0, rd_cnt0, drained0} !== 17'd0) begin
            fails++; $display("FAIL drain_zero got=%0d/%0d/%b exp=0/0/0", wr_cnt0, rd_cnt0, drained0);
        end
        tick();
        #1;
        checks++;
        if ({drained0, slv_resp0.ar_ready} !== 2'b10) begin
            fails++; $display("FAIL drain_drained got=%b exp=10", {drained0, slv_resp0.ar_ready});
        end
        checks++;
        if (obs0 !== exp_obs(0)) begin
            fails++; $display("FAIL drain_model got=%h exp=%h", obs0, exp_obs(0));
        end
        drain = 1'b0;
        tick();
        #1;
        checks++;
        if ({drained0, slv_resp0.ar_ready} !== 2'b01) begin
            fails++; $display("FAIL drain_resume got=%b exp=01", {drained0, slv_resp0.ar_ready});
        end
        tick();
        slv_req.ar_valid = 1'b0;
        #1;
        checks++;
        if (rd_cnt0 !== 8'd1) begin
            fails++; $display("FAIL drain_traffic got=%0d exp=1", rd_cnt0);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        mst_resp.b_valid = 1'b1; slv_req.b_ready = 1'b1;
        tick();
        mst_resp.b_valid = 1'b0;
        #1;
        checks++;
        if ({uf0, wr_cnt0, uf1} !== {1'b1, 8'd0, 1'b1}) begin
            fails++; $display("FAIL underflow_b got=%b/%0d/%b exp=1/0/1", uf0, wr_cnt0, uf1);
        end
        repeat (5) tick();
        #1;
        checks++;
        if (uf0 !== 1'b1) begin
            fails++; $display("FAIL underflow_sticky got=%b exp=1", uf0);
        end
        do_reset();
        #1;
        checks++;
        if (uf0 !== 1'b0) begin
            fails++; $display("FAIL underflow_cleared got=%b exp=0", uf0);
        end
        mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1; slv_req.r_ready = 1'b1;
        tick();
        mst_resp.r_valid = 1'b0;
        #1;
        checks++;
        if ({uf0, rd_cnt0} !== {1'b1, 8'd0}) begin
            fails++; $display("FAIL underflow_r got=%b/%0d exp=1/0", uf0, rd_cnt0);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        slv_req.ar_valid = 1'b1; mst_resp.ar_ready = 1'b1;
        tick();
        slv_req.ar_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            #1;
            checks++;
            if ({to0, to1} !== {(k >= 16), 1'b0}) begin
                fails++; $display("FAIL timeout_cyc%0d got=%b/%b exp=%b/0", k, to0, to1, (k >= 16));
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            slv_req = rand_req(); mst_resp = rand_resp();
            if ($urandom_range(29) == 0) drain = ~drain;
            #1;
            checks++;
            if (obs0 !== exp_obs(0)) begin
                fails++; $display("FAIL random0 cyc=%0d got=%h exp=%h", c, obs0, exp_obs(0));
            end
            checks++;
            if (obs1 !== exp_obs(1)) begin
                fails++; $display("FAIL random1 cyc=%0d got=%h exp=%h", c, obs1, exp_obs(1));
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; slv_req = '0; mst_resp = '0; drain = 1'b0;
        tick();
        test_reset();
        test_wr_limit();
        test_rd_limit();
        test_simultaneous();
        test_drain();
        test_underflow();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit reached without finishing");
        $fatal(1);
    end

endmodule

// File: doc/axi_txn_limiter.md
Name: axi_txn_limiter

Overview:
- Single-clock AXI4 stage placed directly downstream of the dst side of the AXI clock-domain crossing, in front of the memory-side interconnect.
- Caps outstanding write and read transactions, so the narrow CDC FIFOs never back up behind a slow slave.
- Provides a drain handshake so software/PMU can quiesce the port before a dst-domain reset or clock switch.
- Flags protocol underflow and response timeouts as sticky status.

Parameters:
- MaxWrTxns, 8: max outstanding writes (AW accepted, B not yet accepted); legal range 1..255.
- MaxRdTxns, 8: max outstanding reads (AR accepted, last R beat not yet accepted); legal range 1..255.
- TimeoutCycles, 0: cycles without progress before timeout flag sets; 0 disables the watchdog; 32-bit.
- axi_req_t, logic: AXI request struct type (same typedef family as the CDC).
- axi_resp_t, logic: AXI response struct type.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- slv_req_i  in  axi_req_t  request from upstream (CDC dst side)
- slv_resp_o  out  axi_resp_t  response to upstream
- mst_req_o  out  axi_req_t  request to downstream slave
- mst_resp_i  in  axi_resp_t  response from downstream slave
- drain_i  in  1  level request to quiesce; blocks new AW/AR
- drained_o  out  1  high when drained: no outstanding transactions and new AW/AR are blocked
- wr_cnt_o  out  8  outstanding write count
- rd_cnt_o  out  8  outstanding read count
- err_underflow_o  out  1  sticky: B or R-last handshake seen with count 0
- err_timeout_o  out  1  sticky: watchdog expired

Behaviour:
- Reset (async, rst_ni low):
  - Counters 0, FSM RUN, all sticky flags 0, pending flags 0.
  - drained_o = 0, wr_cnt_o = rd_cnt_o = 0.
  - Struct outputs are pure combinational pass-through of inputs, gated as described below.
- Pass-through:
  - W, B and R channels pass combinationally and unmodified.
  - AW and AR payloads pass unmodified; zero added latency.
- Write counter:
  - +1 on mst AW handshake, -1 on mst B handshake; both in the same cycle leaves it unchanged.
  - A decrement at 0 saturates at 0 and sets err_underflow_o.
- Read counter:
  - +1 on mst AR handshake, -1 on mst R handshake with last = 1. Same simultaneous and underflow rules as the write counter.
- AW gate (aw_block):
  - Closes when wr_cnt == MaxWrTxns, or when FSM != RUN, unless aw_pend_q = 1.
  - When closed: mst_req_o.aw_valid = 0 and slv_resp_o.aw_ready = 0.
- AW pending flag: aw_pend_q <= mst aw_valid & !aw_ready. It guarantees an already-presented valid is never withdrawn (AXI rule).
- AR gate: identical to AW, using rd_cnt, MaxRdTxns and ar_pend_q.
- Timing of the gate:
  - Gating uses registered counts only; there is no combinational path from B/R ready/valid to AW/AR valid.
  - At full, a B handshake re-opens AW in the following cycle.
- FSM states:
  - RUN -> DRAIN when drain_i = 1.
  - DRAIN -> DRAINED when wr_cnt = 0, rd_cnt = 0, and no AW/AR handshake occurs this cycle.
  - DRAIN -> RUN if drain_i falls first.
  - DRAINED -> RUN when drain_i = 0.
  - drained_o = (state == DRAINED), registered.
- Watchdog (per direction, 32-bit):
  - Increments while its count > 0 and no B (resp. R-last) handshake occurs.
  - Clears on a handshake or when its count = 0.
  - Reaching TimeoutCycles sets err_timeout_o. The counter then holds and does not wrap.
- Sticky flags clear only on reset.

Test Plan:
- MaxWrTxns = 2, issue 3 back-to-back AWs with B held off -> first 2 pass; 3rd sees slv aw_ready = 0; wr_cnt_o = 2. Release one B -> 3rd AW accepted the next cycle; wr_cnt_o stays 2.
- MaxRdTxns = 1, AR len = 3 -> rd_cnt_o = 1 for all 4 beats; decrements only on the beat with last = 1. A second AR is blocked until then.
- Simultaneous AW handshake and B handshake at wr_cnt = 1 -> wr_cnt_o remains 1; no glitch on mst aw_valid.
- Assert drain_i while 1 write and 2 reads are outstanding, with an AW stalled (valid, not ready):
  - Stalled AW stays valid until accepted; new AR is blocked.
  - drained_o rises 1 cycle after the counts reach 0.
  - Deassert drain_i -> RUN; traffic resumes.
- Inject B with wr_cnt = 0 -> err_underflow_o = 1; wr_cnt_o = 0. Flag persists until rst_ni pulses low.
- TimeoutCycles = 16, one read outstanding and R never valid -> err_timeout_o rises after 16 stalled cycles. With TimeoutCycles = 0 the flag never sets.
